// File: rtl/controlador_micro_ondas_if.sv
// Front-panel and counter-side signals of the microwave controller.
// The "slave" modport is the controller's view; the "master" modport is the
// view of whatever drives the panel inputs and listens to the counter controls.
interface controlador_micro_ondas_if;
    logic       keypad_valid;
    logic [3:0] keypad_digit;
    logic       start_btn;
    logic       stop_btn;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] cnt_data;
    logic       cnt_load;
    logic       cnt_loadn;
    logic       cnt_enable;
    logic       cnt_clearn;
    logic       magnetron_on;
    logic       beep;
    logic [2:0] state;

    modport master (
        output keypad_valid, keypad_digit, start_btn, stop_btn, door_closed, timer_zero,
        input  cnt_data, cnt_load, cnt_loadn, cnt_enable, cnt_clearn, magnetron_on, beep, state
    );

    modport slave (
        input  keypad_valid, keypad_digit, start_btn, stop_btn, door_closed, timer_zero,
        output cnt_data, cnt_load, cnt_loadn, cnt_enable, cnt_clearn, magnetron_on, beep, state
    );
endinterface

// File: rtl/controlador_micro_ondas.sv
// Sequencing FSM for the microwave MM:SS timer: loads keypad digits into the
// counter, paces the once-per-tick decrement while cooking, handles pause,
// cancel and the end-of-cook beep.
module controlador_micro_ondas #(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 50
) (
    input logic                      clock,
    input logic                      clearn,
    controlador_micro_ondas_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_TOP  = BW'(DONE_CYCLES - 1);

    state_t        cur_state, nxt_state;
    logic [3:0]    data_q, data_d;
    logic          load_q, load_d;
    logic          loadn_q, loadn_d;
    logic          en_q, en_d;
    logic          mag_q, mag_d;
    logic          beep_q, beep_d;
    logic          clr_q, clr_d;
    logic [1:0]    dcnt_q, dcnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          start_prev, stop_prev;
    logic          start_ev, stop_ev;

    // Button edges; the prev registers reset high so a held button is not an event.
    assign start_ev = bus.start_btn & ~start_prev;
    assign stop_ev  = bus.stop_btn & ~stop_prev;

    assign bus.cnt_data     = data_q;
    assign bus.cnt_load     = load_q;
    assign bus.cnt_loadn    = loadn_q;
    assign bus.cnt_enable   = en_q;
    assign bus.magnetron_on = mag_q;
    assign bus.beep         = beep_q;
    assign bus.state        = cur_state;
    assign bus.cnt_clearn   = clearn & ~clr_q;

    // State and registered outputs; everything returns to idle on reset.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            cur_state  <= IDLE;
            data_q     <= '0;
            load_q     <= 1'b0;
            loadn_q    <= 1'b0;
            en_q       <= 1'b0;
            mag_q      <= 1'b0;
            beep_q     <= 1'b0;
            clr_q      <= 1'b0;
            dcnt_q     <= '0;
            presc_q    <= '0;
            bcnt_q     <= '0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
        end else begin
            cur_state  <= nxt_state;
            data_q     <= data_d;
            load_q     <= load_d;
            loadn_q    <= loadn_d;
            en_q       <= en_d;
            mag_q      <= mag_d;
            beep_q     <= beep_d;
            clr_q      <= clr_d;
            dcnt_q     <= dcnt_d;
            presc_q    <= presc_d;
            bcnt_q     <= bcnt_d;
            start_prev <= bus.start_btn;
            stop_prev  <= bus.stop_btn;
        end
    end

    // Next state and next output values; a cancel in IDLE takes precedence over entry and start.
    always_comb begin
        nxt_state = cur_state;
        data_d    = data_q;
        load_d    = 1'b0;
        en_d      = 1'b0;
        clr_d     = 1'b0;
        dcnt_d    = dcnt_q;
        presc_d   = presc_q;
        bcnt_d    = bcnt_q;

        case (cur_state)
            IDLE: begin
                if (stop_ev) begin
                    clr_d  = 1'b1;
                    dcnt_d = '0;
                end else begin
                    if (bus.keypad_valid && bus.keypad_digit <= 4'd9 && dcnt_q < 2'd3) begin
                        load_d = 1'b1;
                        data_d = bus.keypad_digit;
                        dcnt_d = dcnt_q + 2'd1;
                    end
                    if (start_ev && bus.door_closed && !bus.timer_zero) begin
                        nxt_state = COOK;
                        presc_d   = '0;
                    end
                end
            end
            COOK: begin
                if (bus.timer_zero) begin
                    nxt_state = DONE;
                    bcnt_d    = '0;
                end else if (!bus.door_closed || stop_ev) begin
                    nxt_state = PAUSE;
                end else if (presc_q == PRESC_TOP) begin
                    en_d    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSE: begin
                if (stop_ev) begin
                    nxt_state = IDLE;
                    clr_d     = 1'b1;
                    dcnt_d    = '0;
                end else if (start_ev && bus.door_closed) begin
                    nxt_state = COOK;
                end
            end
            DONE: begin
                if (stop_ev || bcnt_q == BEEP_TOP) begin
                    nxt_state = IDLE;
                    clr_d     = 1'b1;
                    dcnt_d    = '0;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase

        mag_d   = (nxt_state == COOK);
        beep_d  = (nxt_state == DONE);
        loadn_d = (nxt_state != IDLE);
    end

endmodule

// File: tb/tb_controlador_micro_ondas.sv
// Scoreboard bench for controlador_micro_ondas: the stimulus side runs a
// behavioural model and queues every expected output event; a monitor pops
// and compares whenever the DUT shows an event.
module tb_controlador_micro_ondas;
    localparam int TICK_DIV    = 4;
    localparam int DONE_CYCLES = 8;
    localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic [3:0]  data;
        logic        load;
        logic        loadn;
        logic        en;
        logic        clr;
        logic        mag;
        logic        beep;
    } ev_t;

    logic clock = 1'b0;
    logic clearn = 1'b0;
    controlador_micro_ondas_if bus();

    controlador_micro_ondas #(.TICK_DIV(TICK_DIV), .DONE_CYCLES(DONE_CYCLES)) dut (
        .clock (clock),
        .clearn(clearn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    ev_t exp_q[$];
    int  n_compared = 0;
    int  n_mismatched = 0;
    bit  mon_en = 1'b0;
    int  stim_cyc = 0;
    int  mon_cyc = 0;

    bit btn_start, btn_stop, door_in, tz_in;

    int         m_mode = M_IDLE;
    int         m_digits = 0;
    int         m_phase = 0;
    int         m_beep_left = 0;
    bit         m_start_prev = 1'b1;
    bit         m_stop_prev = 1'b1;
    logic [3:0] m_data = 4'd0;
    logic [2:0] m_last_st = 3'd0;
    logic       m_last_mag = 1'b0;
    logic       m_last_beep = 1'b0;

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d st=%0d data=%0d load=%b loadn=%b en=%b clr=%b mag=%b beep=%b",
                         e.cyc, e.st, e.data, e.load, e.loadn, e.en, e.clr, e.mag, e.beep);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference behaviour for one clock edge, given the inputs applied before it.
    task automatic model_step(input bit kv, input logic [3:0] kd);
        bit  s_ev, p_ev, load, en, clr;
        ev_t e;
        s_ev = btn_start && !m_start_prev;
        p_ev = btn_stop && !m_stop_prev;
        m_start_prev = btn_start;
        m_stop_prev  = btn_stop;
        load = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (p_ev) begin
                    clr = 1'b1;
                    m_digits = 0;
                end else begin
                    if (kv && kd < 10 && m_digits < 3) begin
                        load = 1'b1;
                        m_data = kd;
                        m_digits++;
                    end
                    if (s_ev && door_in && !tz_in) begin
                        m_mode = M_COOK;
                        m_phase = 0;
                    end
                end
            end
            M_COOK: begin
                if (tz_in) begin
                    m_mode = M_DONE;
                    m_beep_left = DONE_CYCLES;
                end else if (!door_in || p_ev) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        en = 1'b1;
                        m_phase = 0;
                    end
                end
            end
            M_PAUSE: begin
                if (p_ev) begin
                    m_mode = M_IDLE;
                    clr = 1'b1;
                    m_digits = 0;
                end else if (s_ev && door_in) begin
                    m_mode = M_COOK;
                end
            end
            default: begin
                if (p_ev || m_beep_left == 1) begin
                    m_mode = M_IDLE;
                    clr = 1'b1;
                    m_digits = 0;
                end else begin
                    m_beep_left--;
                end
            end
        endcase
        stim_cyc++;
        e.cyc   = stim_cyc;
        e.st    = 3'(m_mode);
        e.data  = m_data;
        e.load  = load;
        e.loadn = (m_mode != M_IDLE);
        e.en    = en;
        e.clr   = clr;
        e.mag   = (m_mode == M_COOK);
        e.beep  = (m_mode == M_DONE);
        if (load || en || clr || e.st != m_last_st || e.mag != m_last_mag || e.beep != m_last_beep)
            exp_q.push_back(e);
        m_last_st   = e.st;
        m_last_mag  = e.mag;
        m_last_beep = e.beep;
    endtask

    // Called at a falling edge: drive one cycle of inputs, model it, wait for the next falling edge.
    task automatic apply_stimulus(input bit kv, input logic [3:0] kd);
        bus.keypad_valid = kv;
        bus.keypad_digit = kd;
        bus.start_btn    = btn_start;
        bus.stop_btn     = btn_stop;
        bus.door_closed  = door_in;
        bus.timer_zero   = tz_in;
        model_step(kv, kd);
        @(negedge clock);
    endtask

    task automatic hold(input int n);
        repeat (n) apply_stimulus(1'b0, 4'd0);
    endtask

    // Monitor: after each rising edge, any visible event is checked against the queue head.
    initial begin
        ev_t        a, e;
        logic [2:0] last_st;
        logic       last_mag, last_beep;
        last_st = 3'd0;
        last_mag = 1'b0;
        last_beep = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                mon_cyc++;
                a.cyc   = mon_cyc;
                a.st    = bus.state;
                a.data  = bus.cnt_data;
                a.load  = bus.cnt_load;
                a.loadn = bus.cnt_loadn;
                a.en    = bus.cnt_enable;
                a.clr   = ~bus.cnt_clearn;
                a.mag   = bus.magnetron_on;
                a.beep  = bus.beep;
                if (a.load || a.en || a.clr || a.st != last_st || a.mag != last_mag || a.beep != last_beep) begin
                    n_compared++;
                    if (exp_q.size() == 0) begin
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_event: got %s, required no event", fmt(a));
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            n_mismatched++;
                            $display("[TB] FAIL event: got %s, required %s", fmt(a), fmt(e));
                        end
                    end
                end
                last_st   = a.st;
                last_mag  = a.mag;
                last_beep = a.beep;
            end
        end
    end

    initial begin
        btn_start = 1'b1;
        btn_stop  = 1'b0;
        door_in   = 1'b1;
        tz_in     = 1'b0;
        bus.keypad_valid = 1'b0;
        bus.keypad_digit = 4'd0;
        bus.start_btn    = 1'b1;
        bus.stop_btn     = 1'b0;
        bus.door_closed  = 1'b1;
        bus.timer_zero   = 1'b0;

        // Reset held with start pressed.
        #12;
        check_output("rst_state", 32'(bus.state), 32'd0);
        check_output("rst_cnt_clearn_low", 32'(bus.cnt_clearn), 32'd0);
        check_output("rst_outputs", {bus.cnt_data, bus.cnt_load, bus.cnt_loadn, bus.cnt_enable,
                                     bus.magnetron_on, bus.beep}, 32'd0);
        repeat (2) @(negedge clock);
        clearn = 1'b1;
        @(posedge clock);
        #1;
        check_output("post_rst_state", 32'(bus.state), 32'd0);
        check_output("post_rst_cnt_clearn", 32'(bus.cnt_clearn), 32'd1);
        check_output("post_rst_outputs", {bus.cnt_data, bus.cnt_load, bus.cnt_loadn, bus.cnt_enable,
                                          bus.magnetron_on, bus.beep}, 32'd0);
        @(negedge clock);
        mon_en = 1'b1;

        // Start still held from reset must not cook.
        hold(3);
        btn_start = 1'b0;
        hold(1);

        // Digit entry, with an out-of-range digit and a fourth digit.
        apply_stimulus(1'b1, 4'd12);
        hold(1);
        apply_stimulus(1'b1, 4'd1);
        apply_stimulus(1'b1, 4'd3);
        hold(2);
        apply_stimulus(1'b1, 4'd0);
        hold(1);
        apply_stimulus(1'b1, 4'd5);
        hold(2);

        // Start gating: door open, then timer at zero, then a good start.
        door_in = 1'b0; btn_start = 1'b1; hold(1); btn_start = 1'b0; hold(1); door_in = 1'b1;
        tz_in = 1'b1; btn_start = 1'b1; hold(1); btn_start = 1'b0; hold(1); tz_in = 1'b0;
        btn_start = 1'b1; hold(1); btn_start = 1'b0;
        hold(13);

        // Door opens two cycles after a tick, then resume.
        hold(1);
        door_in = 1'b0;
        hold(3);
        door_in = 1'b1;
        hold(1);
        btn_start = 1'b1; hold(1); btn_start = 1'b0;
        hold(5);

        // Timer reaches zero together with stop: completion wins.
        tz_in = 1'b1; btn_stop = 1'b1; hold(1); btn_stop = 1'b0;
        hold(12);
        tz_in = 1'b0;
        hold(1);

        // Cook, pause by stop, cancel by stop, then three fresh digits plus one extra.
        btn_start = 1'b1; hold(1); btn_start = 1'b0; hold(2);
        btn_stop = 1'b1; hold(1); btn_stop = 1'b0; hold(1);
        btn_stop = 1'b1; hold(1); btn_stop = 1'b0; hold(1);
        apply_stimulus(1'b1, 4'd7);
        apply_stimulus(1'b1, 4'd8);
        apply_stimulus(1'b1, 4'd9);
        apply_stimulus(1'b1, 4'd4);
        hold(2);

        // Randomised panel activity.
        repeat (600) begin
            btn_start = ($urandom_range(0, 9) == 0);
            btn_stop  = ($urandom_range(0, 19) == 0);
            door_in   = ($urandom_range(0, 11) != 0);
            tz_in     = ($urandom_range(0, 14) == 0);
            apply_stimulus(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        hold(2);
        mon_en = 1'b0;
        check_output("expected_events_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of cooking.
        clearn = 1'b0;
        @(negedge clock);
        clearn = 1'b1;
        bus.start_btn = 1'b0;
        bus.stop_btn = 1'b0;
        bus.door_closed = 1'b1;
        bus.timer_zero = 1'b0;
        bus.keypad_valid = 1'b0;
        @(negedge clock);
        bus.start_btn = 1'b1;
        @(negedge clock);
        bus.start_btn = 1'b0;
        @(negedge clock);
        check_output("cook_before_async_rst_state", 32'(bus.state), 32'd1);
        check_output("cook_before_async_rst_mag", 32'(bus.magnetron_on), 32'd1);
        #2;
        clearn = 1'b0;
        #1;
        check_output("async_rst_state", 32'(bus.state), 32'd0);
        check_output("async_rst_mag", 32'(bus.magnetron_on), 32'd0);
        check_output("async_rst_cnt_clearn", 32'(bus.cnt_clearn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
